// File: rtl/cmdout_collector.sv
`default_nettype none
// ============================================================================
// Module   : cmdout_collector
// Brief    : Round-robin, packet-locked merge of per-accelerator command-out
//            AXI-Stream channels into one tid-tagged cmdout stream.
// Revision : 1.0 - initial release
// ============================================================================
module cmdout_collector #(
    parameter int MAX_ACCS = 16
) (
    input  logic                         aclk,
    input  logic                         rst,
    input  logic [MAX_ACCS-1:0]          acc_tvalid,
    output logic [MAX_ACCS-1:0]          acc_tready,
    input  logic [64*MAX_ACCS-1:0]       acc_tdata,
    input  logic [MAX_ACCS-1:0]          acc_tlast,
    output logic                         cmdout_out_tvalid,
    input  logic                         cmdout_out_tready,
    output logic [$clog2(MAX_ACCS)-1:0]  cmdout_out_tid,
    output logic [63:0]                  cmdout_out_tdata
);

    localparam int                 c_TID_W     = $clog2(MAX_ACCS);
    localparam logic [0:0]         c_ST_IDLE   = 1'b0;
    localparam logic [0:0]         c_ST_LOCKED = 1'b1;
    localparam logic [c_TID_W-1:0] c_LAST_IDX  = c_TID_W'(MAX_ACCS - 1);

    logic [0:0]          r_state;
    logic [c_TID_W-1:0]  r_rr_ptr;
    logic [c_TID_W-1:0]  r_grant;
    logic                r_out_tvalid;
    logic [c_TID_W-1:0]  r_out_tid;
    logic [63:0]         r_out_tdata;

    logic                w_sel_found;
    logic [c_TID_W-1:0]  w_sel_idx;
    logic [c_TID_W-1:0]  w_scan_idx;
    int                  w_scan;
    logic                w_slot_free;
    logic                w_accept;
    logic [63:0]         w_grant_data;
    logic [MAX_ACCS-1:0] w_acc_tready;

    // First requester at or above rr_ptr, wrapping explicitly so that a
    // non-power-of-two channel count never yields an out-of-range index.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_scan      = 0;
        w_scan_idx  = '0;
        for (int k = 0; k < MAX_ACCS; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= MAX_ACCS) begin
                w_scan = w_scan - MAX_ACCS;
            end
            w_scan_idx = c_TID_W'(w_scan);
            if (!w_sel_found && acc_tvalid[w_scan_idx]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_scan_idx;
            end
        end
    end

    assign w_slot_free  = !r_out_tvalid || cmdout_out_tready;
    assign w_grant_data = acc_tdata[{r_grant, 6'b0} +: 64];
    assign w_accept     = (r_state == c_ST_LOCKED) && acc_tvalid[r_grant] && w_slot_free;

    always_comb begin
        w_acc_tready = '0;
        if (r_state == c_ST_LOCKED) begin
            w_acc_tready[r_grant] = w_slot_free;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_out_tvalid <= 1'b0;
            r_out_tid    <= '0;
            r_out_tdata  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_sel_found) begin
                        r_grant <= w_sel_idx;
                        r_state <= c_ST_LOCKED;
                    end
                end
                c_ST_LOCKED: begin
                    // Grant is held until the packet's tlast beat is taken.
                    if (w_accept && acc_tlast[r_grant]) begin
                        r_rr_ptr <= (r_grant == c_LAST_IDX) ? '0 : r_grant + 1'b1;
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (w_accept) begin
                r_out_tvalid <= 1'b1;
                r_out_tid    <= r_grant;
                r_out_tdata  <= w_grant_data;
            end else if (r_out_tvalid && cmdout_out_tready) begin
                r_out_tvalid <= 1'b0;
            end
        end
    end

    assign acc_tready        = w_acc_tready;
    assign cmdout_out_tvalid = r_out_tvalid;
    assign cmdout_out_tid    = r_out_tid;
    assign cmdout_out_tdata  = r_out_tdata;

endmodule
`default_nettype wire

// File: tb/tb_cmdout_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmdout_collector
// Brief    : Scoreboard bench for cmdout_collector arbitration and streaming.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmdout_collector;

    localparam int c_N = 16;

    typedef struct {
        logic [3:0]  tid;
        logic [63:0] data;
        int          gap;
    } exp_t;

    logic              aclk;
    logic              rst;
    logic [c_N-1:0]    acc_tvalid;
    logic [c_N-1:0]    acc_tready;
    logic [64*c_N-1:0] acc_tdata;
    logic [c_N-1:0]    acc_tlast;
    logic              cmdout_out_tvalid;
    logic              cmdout_out_tready;
    logic [3:0]        cmdout_out_tid;
    logic [63:0]       cmdout_out_tdata;

    cmdout_collector #(.MAX_ACCS(c_N)) dut (
        .aclk              (aclk),
        .rst               (rst),
        .acc_tvalid        (acc_tvalid),
        .acc_tready        (acc_tready),
        .acc_tdata         (acc_tdata),
        .acc_tlast         (acc_tlast),
        .cmdout_out_tvalid (cmdout_out_tvalid),
        .cmdout_out_tready (cmdout_out_tready),
        .cmdout_out_tid    (cmdout_out_tid),
        .cmdout_out_tdata  (cmdout_out_tdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Per-accelerator source model: a small beat memory with read/write pointers.
    logic [63:0] src_d [c_N][16];
    logic        src_l [c_N][16];
    int          src_wr [c_N];
    int          src_rd [c_N];
    logic        src_hold [c_N];

    exp_t        exp_q[$];
    int          cyc, checks, failures;
    int          first_valid_cyc, last_pop_cyc;
    logic        prev_stall;
    logic [3:0]  prev_tid;
    logic [63:0] prev_data;
    logic [c_N-1:0] hs;

    function automatic bit src_pending();
        for (int i = 0; i < c_N; i++) if (src_rd[i] < src_wr[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < c_N; i++) begin
            if (src_rd[i] < src_wr[i] && !src_hold[i]) begin
                acc_tvalid[i]          = 1'b1;
                acc_tdata[i*64 +: 64]  = src_d[i][src_rd[i]];
                acc_tlast[i]           = src_l[i][src_rd[i]];
            end else begin
                acc_tvalid[i]          = 1'b0;
                acc_tdata[i*64 +: 64]  = '0;
                acc_tlast[i]           = 1'b0;
            end
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < c_N; i++) begin
            src_wr[i]   = 0;
            src_rd[i]   = 0;
            src_hold[i] = 1'b0;
        end
        exp_q.delete();
        hs         = '0;
        prev_stall = 1'b0;
    endtask

    // Queue a packet on accelerator a and its expected output beats.
    task automatic send_pkt(input int a, input logic [63:0] base, input int n,
                            input int first_gap, input int rest_gap);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            src_d[a][src_wr[a]] = base + 64'(k);
            src_l[a][src_wr[a]] = (k == n - 1);
            src_wr[a]++;
            e.tid  = 4'(a);
            e.data = base + 64'(k);
            e.gap  = (k == 0) ? first_gap : rest_gap;
            exp_q.push_back(e);
        end
        drive_inputs();
    endtask

    task automatic cycle();
        exp_t e;
        cyc++;
        @(negedge aclk);
        hs = '0;
        if (!rst) begin
            if (cmdout_out_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                checks++;
                if (!cmdout_out_tvalid || cmdout_out_tid !== prev_tid || cmdout_out_tdata !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold: tvalid=%0b tid=%0d data=%h required tvalid=1 tid=%0d data=%h",
                             cmdout_out_tvalid, cmdout_out_tid, cmdout_out_tdata, prev_tid, prev_data);
                end
            end
            if (cmdout_out_tvalid && !cmdout_out_tready) begin
                checks++;
                if (acc_tready !== '0) begin
                    failures++;
                    $display("FAIL stall_ready: acc_tready=%h required 0000", acc_tready);
                end
            end
            checks++;
            if (!$onehot0(acc_tready)) begin
                failures++;
                $display("FAIL ready_onehot: acc_tready=%h required at most one bit", acc_tready);
            end
            if (cmdout_out_tvalid && cmdout_out_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected: tid=%0d data=%h required no beat", cmdout_out_tid, cmdout_out_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (cmdout_out_tid !== e.tid || cmdout_out_tdata !== e.data) begin
                        failures++;
                        $display("FAIL out_beat: tid=%0d data=%h required tid=%0d data=%h",
                                 cmdout_out_tid, cmdout_out_tdata, e.tid, e.data);
                    end
                    if (e.gap > 0) begin
                        checks++;
                        if (cyc - last_pop_cyc != e.gap) begin
                            failures++;
                            $display("FAIL out_gap: actual=%0d required=%0d", cyc - last_pop_cyc, e.gap);
                        end
                    end
                end
                last_pop_cyc = cyc;
            end
            prev_stall = cmdout_out_tvalid && !cmdout_out_tready;
            prev_tid   = cmdout_out_tid;
            prev_data  = cmdout_out_tdata;
            hs         = acc_tvalid & acc_tready;
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < c_N; i++) if (hs[i]) src_rd[i]++;
        drive_inputs();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < 200) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || src_pending()) begin
            failures++;
            $display("FAIL drain_timeout: pending_beats=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        drive_inputs();
        cmdout_out_tready = 1'b1;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_sources();
        src_d[2][0] = 64'h55; src_l[2][0] = 1'b1; src_wr[2] = 1;
        drive_inputs();
        cmdout_out_tready = 1'b0;
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        checks++;
        if (cmdout_out_tvalid !== 1'b0 || cmdout_out_tid !== 4'd0 || cmdout_out_tdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_out: tvalid=%0b tid=%0d data=%h required 0 0 0",
                     cmdout_out_tvalid, cmdout_out_tid, cmdout_out_tdata);
        end
        checks++;
        if (acc_tready !== '0) begin
            failures++;
            $display("FAIL reset_ready: acc_tready=%h required 0000", acc_tready);
        end
        do_reset();
    endtask

    task automatic test_single();
        int start;
        do_reset();
        send_pkt(3, 64'hA0, 3, 0, 1);
        send_pkt(3, 64'hB0, 1, 2, 1);
        start = cyc;
        first_valid_cyc = -1;
        drain();
        checks++;
        if (first_valid_cyc - (start + 1) != 2) begin
            failures++;
            $display("FAIL single_latency: actual=%0d required=2", first_valid_cyc - (start + 1));
        end
        checks++;
        if (acc_tready !== '0) begin
            failures++;
            $display("FAIL single_idle_ready: acc_tready=%h required 0000", acc_tready);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            send_pkt(0,  64'h1000 + 64'(p * 16), 2, (p == 0) ? 0 : 2, 1);
            send_pkt(5,  64'h5000 + 64'(p * 16), 2, 2, 1);
            send_pkt(15, 64'hF000 + 64'(p * 16), 2, 2, 1);
        end
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        send_pkt(14, 64'hE0, 1, 0, 0);
        drain();
        send_pkt(15, 64'hF0, 1, 0, 0);
        drain();
        send_pkt(2,  64'h20, 1, 0, 0);
        send_pkt(14, 64'hE8, 1, 2, 0);
        drain();
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        send_pkt(7, 64'h7700, 4, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cmdout_out_tready = pat[k % 4];
            cycle();
        end
        cmdout_out_tready = 1'b1;
        drain();
    endtask

    task automatic test_locked();
        int n;
        do_reset();
        send_pkt(1, 64'h1100, 4, 0, 0);
        send_pkt(4, 64'h4400, 2, 2, 1);
        n = 0;
        while (src_rd[1] < 1 && n < 20) begin
            cycle();
            n++;
        end
        src_hold[1] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (acc_tready[4] !== 1'b0) begin
                failures++;
                $display("FAIL locked_other_ready: acc_tready[4]=%0b required 0", acc_tready[4]);
            end
        end
        src_hold[1] = 1'b0;
        drive_inputs();
        drain();
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        send_pkt(9, 64'h9900, 1, 0, 0);
        drain();
        send_pkt(6, 64'h6600, 4, 0, 0);
        n = 0;
        while (src_rd[6] < 1 && n < 20) begin
            cycle();
            n++;
        end
        rst = 1'b1;
        clear_sources();
        drive_inputs();
        @(posedge aclk);
        #1;
        rst = 1'b0;
        checks++;
        if (cmdout_out_tvalid !== 1'b0 || acc_tready !== '0) begin
            failures++;
            $display("FAIL reset_mid: tvalid=%0b acc_tready=%h required 0 0000", cmdout_out_tvalid, acc_tready);
        end
        send_pkt(0,  64'hC0, 1, 0, 0);
        send_pkt(12, 64'hD0, 1, 2, 0);
        drain();
    endtask

    initial begin
        cyc = 0; checks = 0; failures = 0;
        first_valid_cyc = -1; last_pop_cyc = 0;
        rst = 1'b1;
        acc_tvalid = '0; acc_tdata = '0; acc_tlast = '0;
        cmdout_out_tready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_locked();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
